// File: rtl/root_module400_pkg.sv
// Shared constants and types for the root_module400 leaf dispatch branch.
package root_module400_pkg;
    localparam int DATA_W    = 16;
    localparam int NUM_PORTS = 5;
    localparam int DEPTH     = 4;
    localparam int CNT_W     = 16;

    typedef logic [DATA_W-1:0] leaf_word_t;

    // Occupancy view of the FIFO, exported for debug and checker binding.
    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } occ_state_t;
endpackage

// File: rtl/root_module400_leaf_dispatch_if.sv
// Bundle of the dispatcher's upstream stream, fan-out ports and status outputs.
interface root_module400_leaf_dispatch_if #(
    parameter int DATA_W    = root_module400_pkg::DATA_W,
    parameter int NUM_PORTS = root_module400_pkg::NUM_PORTS,
    parameter int DEPTH     = root_module400_pkg::DEPTH,
    parameter int CNT_W     = root_module400_pkg::CNT_W
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    // Handshake: a word moves on a rising edge exactly when valid and ready are
    // both high; valid never depends on ready, and ready never depends on valid.
    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_data;
    logic [NUM_PORTS-1:0]  out_valid;
    logic [NUM_PORTS-1:0]  out_ready;
    logic [DATA_W-1:0]     out_data;
    logic [LVL_W-1:0]      level;
    logic [CNT_W-1:0]      sent_cnt;
    root_module400_pkg::occ_state_t occ_state;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, sent_cnt, occ_state
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, sent_cnt, occ_state
    );
endinterface

// File: rtl/root_module400_fwft_fifo.sv
// First-word-fall-through FIFO; occupancy kept in a separate level register
// so the naturally wrapping pointers never need an extra wrap bit.
module root_module400_fwft_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);
endmodule

// File: rtl/root_module400_leaf_dispatch.sv
// Round-robin stream dispatcher: buffers words and offers each head word to
// the leaf ports strictly in order 0..NUM_PORTS-1, stalling on the target port.
module root_module400_leaf_dispatch
    import root_module400_pkg::*;
(
    input logic                          clk,
    input logic                          rst_n,
    root_module400_leaf_dispatch_if.slave bus
);
    localparam int RR_W  = $clog2(NUM_PORTS);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             full;
    logic             empty;
    logic             offer;
    logic             push;
    logic             pop;
    leaf_word_t       head;
    logic [LVL_W-1:0] level;
    logic [RR_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] sent_cnt;

    root_module400_fwft_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LVL_W  (LVL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .push      (push),
        .pop       (pop),
        .push_data (bus.in_data),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // Only the target port's ready bit is looked at; the others cannot pop.
    assign offer         = !empty && !bus.flush;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = offer && bus.out_ready[rr_ptr];
    assign bus.in_ready  = !full && !bus.flush;
    assign bus.out_valid = offer ? (NUM_PORTS'(1) << rr_ptr) : '0;
    assign bus.out_data  = head;
    assign bus.level     = level;
    assign bus.sent_cnt  = sent_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (bus.flush) begin
            rr_ptr <= '0;
        end else if (pop) begin
            rr_ptr <= (rr_ptr == RR_W'(NUM_PORTS - 1)) ? '0 : rr_ptr + 1'b1;
        end
    end

    // Flush leaves the delivered count alone; it only counts real pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sent_cnt <= '0;
        end else if (pop) begin
            sent_cnt <= sent_cnt + 1'b1;
        end
    end

    always_comb begin
        bus.occ_state = OCC_PARTIAL;
        if (empty) begin
            bus.occ_state = OCC_EMPTY;
        end else if (full) begin
            bus.occ_state = OCC_FULL;
        end
    end
endmodule

// File: tb/tb_root_module400_leaf_dispatch.sv
// Randomised and directed bench for the leaf dispatcher with a queue-based
// reference model compared on every falling edge.
module tb_root_module400_leaf_dispatch;
    import root_module400_pkg::*;

    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    logic [DATA_W-1:0] exp_q[$];
    int                m_rr;
    logic [CNT_W-1:0]  m_sent;

    root_module400_leaf_dispatch_if bus ();

    root_module400_leaf_dispatch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    // reference model: a word queue, a target port index and a delivered count
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rr   = 0;
            m_sent = '0;
        end else if (bus.flush) begin
            exp_q.delete();
            m_rr = 0;
        end else begin
            automatic int  sz      = exp_q.size();
            automatic bit  do_push = bus.in_valid && (sz < DEPTH);
            automatic bit  do_pop  = (sz > 0) && bus.out_ready[m_rr];
            if (do_pop) begin
                void'(exp_q.pop_front());
                m_rr   = (m_rr + 1) % NUM_PORTS;
                m_sent = m_sent + 1'b1;
            end
            if (do_push) begin
                exp_q.push_back(bus.in_data);
            end
        end
    end

    // scoreboard compare on every cycle outside reset
    always @(negedge clk) begin
        if (rst_n) begin
            automatic bit              has = (exp_q.size() > 0) && !bus.flush;
            automatic logic [NUM_PORTS-1:0] ev = has ? NUM_PORTS'(1 << m_rr) : '0;
            check("out_valid", 32'(bus.out_valid), 32'(ev));
            if (has) begin
                check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
            end
            check("in_ready", 32'(bus.in_ready), 32'((exp_q.size() < DEPTH) && !bus.flush));
            check("level", 32'(bus.level), 32'(exp_q.size()));
            check("sent_cnt", 32'(bus.sent_cnt), 32'(m_sent));
        end
    end

    initial begin
        int guard;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive_idle();
        step(2);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check("rst_level", 32'(bus.level), 32'h0);
        check("rst_sent_cnt", 32'(bus.sent_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        // in-order delivery to ports 0..4, one word per cycle
        bus.out_ready = '1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(i + 1);
            step();
            check("t1_port", 32'(bus.out_valid), 32'(1 << i));
            check("t1_data", 32'(bus.out_data), 32'(i + 1));
        end
        bus.in_valid = 1'b0;
        step(2);
        check("t1_sent", 32'(bus.sent_cnt), 32'd5);
        check("t1_idle", 32'(bus.out_valid), 32'h0);

        // fill with all ports stalled, then release port 0 for one pop
        bus.out_ready = '0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(16'h0200 + i);
            step();
        end
        bus.in_valid = 1'b0;
        check("t2_level_full", 32'(bus.level), 32'd4);
        check("t2_ready_low", 32'(bus.in_ready), 32'h0);
        bus.out_ready = 5'b00001;
        step();
        bus.out_ready = '0;
        check("t2_level", 32'(bus.level), 32'd3);
        check("t2_ready_high", 32'(bus.in_ready), 32'h1);
        check("t2_sent", 32'(bus.sent_cnt), 32'd6);
        do_flush();

        // port 1 stalled blocks every other port
        bus.out_ready = 5'b11101;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(16'h0301 + i);
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", 32'(bus.out_valid), 32'b00010);
            check("t3_hold_sent", 32'(bus.sent_cnt), 32'd7);
            step();
        end
        bus.out_ready = '1;
        step(4);
        check("t3_sent", 32'(bus.sent_cnt), 32'd9);
        do_flush();

        // steady simultaneous push and pop at level 2
        bus.out_ready = '0;
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(16'h0401 + i);
            step();
        end
        bus.out_ready = '1;
        for (int i = 0; i < 16; i++) begin
            bus.in_data = DATA_W'(16'h0410 + i);
            step();
            check("t4_level", 32'(bus.level), 32'd2);
            check("t4_ready", 32'(bus.in_ready), 32'h1);
        end
        bus.in_valid = 1'b0;
        step(3);
        check("t4_sent", 32'(bus.sent_cnt), 32'd27);
        do_flush();

        // flush at level 3, target port 2, with a push pending
        bus.out_ready = 5'b00011;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DATA_W'(16'h0501 + i);
            step();
        end
        check("t5_pre_level", 32'(bus.level), 32'd3);
        check("t5_pre_port", 32'(bus.out_valid), 32'b00100);
        bus.flush   = 1'b1;
        bus.in_data = 16'h05FF;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("t5_level", 32'(bus.level), 32'd0);
        check("t5_valid", 32'(bus.out_valid), 32'h0);
        check("t5_sent", 32'(bus.sent_cnt), 32'd29);
        bus.out_ready = '0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 16'h0510;
        step();
        bus.in_valid = 1'b0;
        check("t5_rr_zero", 32'(bus.out_valid), 32'b00001);
        check("t5_new_word", 32'(bus.out_data), 32'h0510);
        bus.out_ready = '1;
        step();

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = DATA_W'($urandom);
            bus.out_ready = NUM_PORTS'($urandom_range(0, 31));
            bus.flush     = ($urandom_range(0, 40) == 0);
            step();
        end
        drive_idle();

        // run the delivered counter up to its wrap point
        bus.in_valid  = 1'b1;
        bus.out_ready = '1;
        guard = 0;
        while (m_sent != 16'hFFFF && guard < 70000) begin
            bus.in_data = DATA_W'($urandom);
            step();
            guard++;
        end
        if (guard >= 70000) begin
            miscompares++;
            $display("FAIL wrap_timeout: got %0h expected ffff", bus.sent_cnt);
        end
        bus.out_ready = '0;
        bus.in_valid  = 1'b0;
        check("t6_sent_max", 32'(bus.sent_cnt), 32'h0000FFFF);
        bus.out_ready = '1;
        step();
        check("t6_sent_wrap", 32'(bus.sent_cnt), 32'h0);

        // asynchronous reset in the middle of a stream
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = DATA_W'(16'h0700 + i);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'h0);
        check("arst_in_ready", 32'(bus.in_ready), 32'h1);
        check("arst_level", 32'(bus.level), 32'h0);
        check("arst_sent_cnt", 32'(bus.sent_cnt), 32'h0);
        drive_idle();
        step(2);
        rst_n = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/root_module400_leaf_dispatch.md
# root_module400_leaf_dispatch

Leaf-level stream dispatcher that feeds the five sibling leaf instances of a root-module branch. Accepts a single valid/ready word stream, buffers it in a small first-word-fall-through FIFO, and hands words to the output ports in strict round-robin order: port 0, 1, 2, 3, 4, then back to 0. Sits directly upstream of the leaf instances and gives each of them a data source with backpressure.

## Interface
- DATA_W, 16, word width
- NUM_PORTS, 5, number of downstream ports; valid range ≥ 2
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- CNT_W, 16, width of the delivered-word counter
- clk  input  1  single clock; all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous clear of FIFO contents and round-robin pointer
- in_valid  input  1  upstream word valid
- in_ready  output  1  dispatcher can accept a word this cycle
- in_data  input  DATA_W  upstream word
- out_valid  output  NUM_PORTS  one-hot; bit p is set when port p is offered the head word
- out_ready  input  NUM_PORTS  per-port accept
- out_data  output  DATA_W  head word, shared by all ports
- level  output  $clog2(DEPTH+1)  current FIFO occupancy
- sent_cnt  output  CNT_W  total words delivered, modulo 2^CNT_W

## Operation
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low; polarity and synchronicity are fixed.
- Push:
  - `in_ready = !full && !flush`.
  - A push occurs when `in_valid && in_ready`.
  - The word is written at `wr_ptr`.
- Pop:
  - `out_valid = (!empty && !flush) << rr_ptr`.
  - A pop occurs when `out_valid[rr_ptr] && out_ready[rr_ptr]`.
  - On a pop, `rd_ptr` increments and `rr_ptr` advances modulo NUM_PORTS, so NUM_PORTS-1 wraps to 0.
- Strict ordering:
  - A stalled target port blocks all other ports.
  - The pointer never skips a port.
  - `out_ready` bits of non-target ports are ignored.
- Occupancy state, derived from `level`:
  - EMPTY (level 0): push only. Goes to PARTIAL.
  - PARTIAL: push without pop raises level and may go to FULL. Pop without push lowers level and may go to EMPTY. Simultaneous push and pop leave level unchanged.
  - FULL (level DEPTH): pop only, because `in_ready` = 0. Goes to PARTIAL.
- Pointers:
  - `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap naturally.
  - Occupancy is tracked by a separate `level` register.
- `sent_cnt` increments by 1 on every pop and wraps from 2^CNT_W−1 to 0.
- flush:
  - Clears `level`, `wr_ptr`, `rd_ptr` and `rr_ptr` to 0.
  - Overrides any push or pop in the same cycle; that push and pop do not happen.
  - Does not clear `sent_cnt`.
- Reset values: `level` = 0, all pointers = 0, `sent_cnt` = 0, `out_valid` = 0, `in_ready` = 1.
- `out_data` reads from storage, so its value is don't-care while `out_valid` = 0.
- Reset mid-transfer discards all buffered words; the word being offered at that moment is not counted in `sent_cnt`.

## Timing
- Latency: a word pushed at edge k is offered on `out_data`/`out_valid` in cycle k+1. There is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on registered `level` and on `flush`; there is no path from `out_ready`.
- `out_valid` depends only on registered state and on `flush`.
- Throughput: 1 word per cycle sustained when the target port is ready every cycle.
- Full FIFO plus a same-cycle pop: `in_ready` stays 0 that cycle. The freed slot accepts a push in the next cycle, a one-cycle bubble that is accepted by design.
- `level`, `sent_cnt` and `rr_ptr` update at the edge where the event occurs.

## Structure
- Shared package `root_module400_pkg` holds:
  - default constants DATA_W, NUM_PORTS, DEPTH;
  - the `leaf_word_t` typedef (`logic [DATA_W-1:0]`).
- Sub-module `root_module400_fwft_fifo`:
  - contains the storage array, `wr_ptr`, `rd_ptr` and `level`;
  - exposes push/pop strobes, full/empty, flush and head data.
- The top level contains only the round-robin pointer, valid/ready decode and `sent_cnt`.

## Test plan
- Reset then push 0x0001 through 0x0005, all `out_ready` = 1: words appear on ports 0, 1, 2, 3, 4 in order, one per cycle. First offer is 1 cycle after push, then `rr_ptr` = 0 and `sent_cnt` = 5.
- All `out_ready` = 0 and 6 words offered: 4 accepted, `in_ready` drops after the 4th, `level` = 4. Releasing `out_ready` = 5'b00001 delivers one word, and `in_ready` rises the next cycle.
- Port 1 stalled for 10 cycles while ports 0 and 2–4 are ready: after word 0 reaches port 0, no further pop occurs. `out_valid` = 5'b00010 holds and `sent_cnt` = 1 until port 1 accepts.
- Steady flow with simultaneous push and pop at `level` = 2: `level` stays at 2, data order is preserved, and `in_ready` = 1 every cycle.
- flush asserted at `level` = 3 with `rr_ptr` = 2 and a push pending: next cycle `level` = 0, `rr_ptr` = 0, the pushed word is dropped and `sent_cnt` is unchanged.
- Preload `sent_cnt` to 0xFFFF via 65535 pops, then one more pop: `sent_cnt` = 0x0000. Assert `rst_n` low asynchronously mid-stream: outputs go to reset values with no clock edge needed.
